// File: rtl/taylor_trig_engine.sv
// Iterative fixed-point cos/sin via Taylor series: one shared multiplier, reciprocal ROM, threshold/term-cap stop.
// Latency: 2 + 3*N cycles from accepted start to the done pulse, N = iterations evaluated.
// Backpressure: start is accepted only while ready=1; requests made during a run are ignored.
module taylor_trig_engine #(
   parameter int W         = 16,
   parameter int FRAC      = 8,
   parameter int MAX_TERMS = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               mode,
   input  logic [W-1:0]                       x_in,
   input  logic [W-1:0]                       thr_in,
   output logic                               ready,
   output logic                               done,
   output logic [W-1:0]                       w,
   output logic [$clog2(MAX_TERMS+1)-1:0]     terms
);

   // Two guard bits above W so intermediate terms and the running sum can exceed the output range.
   localparam int AW = W + 2;
   localparam int PW = 2 * AW;
   localparam int KW = $clog2(MAX_TERMS + 1);
   localparam int RN = 1 << KW;
   localparam logic [KW-1:0]        K_CAP = KW'(MAX_TERMS);
   localparam logic signed [AW-1:0] ONE   = AW'(1 << FRAC);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQ,
      S_MULX,
      S_MULR,
      S_CHECK,
      S_DONE
   } state_t;

   state_t state, next_state;

   logic signed [W-1:0]  x_r;
   logic [W-1:0]         thr_r;
   logic                 mode_r;
   logic signed [AW-1:0] x2;
   logic signed [AW-1:0] term;
   logic signed [AW-1:0] acc;
   logic [KW-1:0]        k;

   logic signed [AW-1:0] x_ext;
   logic signed [AW-1:0] mul_a;
   logic signed [AW-1:0] mul_b;
   logic signed [PW-1:0] mul_p;
   logic signed [AW-1:0] mul_t;
   logic signed [AW-1:0] rom_k;
   logic signed [AW-1:0] rom_cos [RN];
   logic signed [AW-1:0] rom_sin [RN];
   logic [AW:0]          term_abs;
   logic                 term_small;
   logic [KW-1:0]        k_inc;
   logic [W-1:0]         acc_sat;
   logic                 unused_bits;

   // Reciprocal coefficient round(2^FRAC / d); entries past the term cap are never addressed and read 0.
   function automatic int rom_val(input int idx, input bit sin_sel);
      int d;
      int r;
      d = sin_sel ? (2 * idx + 2) * (2 * idx + 3) : (2 * idx + 1) * (2 * idx + 2);
      r = ((2 << FRAC) + d) / (2 * d);
      if (idx >= MAX_TERMS) r = 0;
      return r;
   endfunction

   for (genvar g = 0; g < RN; g++) begin : g_rom
      assign rom_cos[g] = AW'(rom_val(g, 1'b0));
      assign rom_sin[g] = AW'(rom_val(g, 1'b1));
   end

   assign x_ext = {{2{x_r[W-1]}}, x_r};
   assign rom_k = mode_r ? rom_sin[k] : rom_cos[k];

   // Full-width signed product; taking bits [FRAC +: AW] is floor(>>FRAC) then truncation.
   assign mul_p       = PW'(mul_a) * PW'(mul_b);
   assign mul_t       = mul_p[FRAC +: AW];
   assign unused_bits = ^{mul_p[PW-1:FRAC+AW], mul_p[FRAC-1:0]};

   // Magnitude needs one extra bit so the most negative term does not wrap.
   assign term_abs   = term[AW-1] ? -{term[AW-1], term} : {term[AW-1], term};
   assign term_small = term_abs < (AW+1)'(thr_r);
   assign k_inc      = k + 1'b1;

   assign acc_sat = ((acc[AW-1:W-1] == '0) || (acc[AW-1:W-1] == '1)) ? acc[W-1:0] :
                    (acc[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});

   // Route the shared multiplier: x*x while squaring, term*x2, then term*R[k].
   always_comb begin
      mul_a = x_ext;
      mul_b = x_ext;
      case (state)
         S_MULX: begin
            mul_a = term;
            mul_b = x2;
         end
         S_MULR: begin
            mul_a = term;
            mul_b = rom_k;
         end
         default: ;
      endcase
   end

   // State register; reset aborts any run in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   // Next-state selection and the ready flag.
   always_comb begin
      next_state = state;
      ready      = (state == S_IDLE);
      case (state)
         S_IDLE:  if (start) next_state = S_SQ;
         S_SQ:    next_state = S_MULX;
         S_MULX:  next_state = S_MULR;
         S_MULR:  next_state = S_CHECK;
         S_CHECK: begin
            if (term_small || (k_inc == K_CAP)) next_state = S_DONE;
            else                                next_state = S_MULX;
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Datapath: capture operands, step the series one term per three cycles, publish the result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_r    <= '0;
         thr_r  <= '0;
         mode_r <= 1'b0;
         x2     <= '0;
         term   <= '0;
         acc    <= '0;
         k      <= '0;
         w      <= '0;
         terms  <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  x_r    <= x_in;
                  thr_r  <= thr_in;
                  mode_r <= mode;
               end
            end
            S_SQ: begin
               x2   <= mul_t;
               term <= mode_r ? x_ext : ONE;
               acc  <= mode_r ? x_ext : ONE;
               k    <= '0;
            end
            S_MULX: term <= mul_t;
            S_MULR: term <= -mul_t;
            S_CHECK: begin
               // A term below threshold is dropped, not added.
               if (!term_small) begin
                  acc <= acc + term;
                  k   <= k_inc;
               end
            end
            S_DONE: begin
               w     <= acc_sat;
               terms <= k;
               done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_taylor_trig_engine.sv
// Bench for taylor_trig_engine: two instances (term cap 8 and 4) share stimulus.
// A series-level reference model predicts result, term count and done timing; outputs compared every cycle.
// Directed cases pin the model to hand-computed Q8.8 values, then randomized runs follow.
module tb_taylor_trig_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [15:0] x_in;
   logic [15:0] thr_in;

   logic        ready8, done8;
   logic [15:0] w8;
   logic [3:0]  terms8;
   logic        ready4, done4;
   logic [15:0] w4;
   logic [2:0]  terms4;

   always #5 clk = ~clk;

   taylor_trig_engine #(.W(16), .FRAC(8), .MAX_TERMS(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .x_in(x_in), .thr_in(thr_in),
      .ready(ready8), .done(done8), .w(w8), .terms(terms8)
   );

   taylor_trig_engine #(.W(16), .FRAC(8), .MAX_TERMS(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .x_in(x_in), .thr_in(thr_in),
      .ready(ready4), .done(done4), .w(w4), .terms(terms4)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   typedef struct packed {
      logic signed [63:0] w;
      logic [31:0]        t;
      logic [31:0]        n;
   } res_t;

   // Wrap to an 18-bit signed value (16-bit data plus two guard bits).
   function automatic longint tr(input longint v);
      longint m;
      m = v & 64'h3FFFF;
      if (m >= 64'h20000) m = m - 64'h40000;
      return m;
   endfunction

   function automatic longint sat16(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic longint rom_r(input int k, input bit s);
      real d;
      d = s ? real'((2 * k + 2) * (2 * k + 3)) : real'((2 * k + 1) * (2 * k + 2));
      return longint'($rtoi(256.0 / d + 0.5));
   endfunction

   function automatic int maxt(input int d);
      return (d == 0) ? 8 : 4;
   endfunction

   // Series evaluation straight from the arithmetic rules.
   function automatic res_t ref_trig(input bit m, input longint x, input longint thr, input int cap);
      res_t   r;
      longint x2, term, acc, mag;
      int     k, n;
      bit     stop;
      x2   = tr((x * x) >>> 8);
      term = m ? x : 256;
      acc  = term;
      k    = 0;
      n    = 0;
      stop = 1'b0;
      while (!stop) begin
         n++;
         term = tr((term * x2) >>> 8);
         term = tr(-((term * rom_r(k, m)) >>> 8));
         mag  = (term < 0) ? -term : term;
         if (mag < thr) stop = 1'b1;
         else begin
            acc = tr(acc + term);
            k++;
            if (k == cap) stop = 1'b1;
         end
      end
      r.w = sat16(acc);
      r.t = k;
      r.n = n;
      return r;
   endfunction

   function automatic int ref_lat(input bit m, input longint x, input longint thr, input int cap);
      res_t r;
      r = ref_trig(m, x, thr, cap);
      return 2 + 3 * int'(r.n);
   endfunction

   // Cycle-level expectation: countdown to done per instance.
   res_t   pend   [2];
   int     m_cnt  [2];
   longint m_w    [2];
   int     m_t    [2];
   bit     m_done [2];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            m_cnt[d]  <= 0;
            m_w[d]    <= 0;
            m_t[d]    <= 0;
            m_done[d] <= 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            m_done[d] <= 1'b0;
            if (m_cnt[d] > 0) begin
               m_cnt[d] <= m_cnt[d] - 1;
               if (m_cnt[d] == 1) begin
                  m_w[d]    <= pend[d].w;
                  m_t[d]    <= int'(pend[d].t);
                  m_done[d] <= 1'b1;
               end
            end else if (start) begin
               pend[d]  <= ref_trig(mode, longint'($signed(x_in)), longint'(thr_in), maxt(d));
               m_cnt[d] <= ref_lat(mode, longint'($signed(x_in)), longint'(thr_in), maxt(d));
            end
         end
      end
   end

   // Compare every output of both instances on each falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("ready8", ready8, m_cnt[0] == 0);
         check("done8", done8, m_done[0]);
         check("w8", $signed(w8), m_w[0]);
         check("terms8", terms8, m_t[0]);
         check("ready4", ready4, m_cnt[1] == 0);
         check("done4", done4, m_done[1]);
         check("w4", $signed(w4), m_w[1]);
         check("terms4", terms4, m_t[1]);
      end
   end

   int     lat   [2];
   longint got_w [2];
   int     got_t [2];
   int     n_done8;

   // Start one run once both instances are idle; record latency and result of the first done of each.
   task automatic run(input bit m, input logic [15:0] x, input logic [15:0] t, input int hold);
      int waited;
      int c;
      bit seen8, seen4;
      waited = 0;
      @(negedge clk);
      while (!(ready8 && ready4) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("idle_wait", waited < 200, 1);
      start   = 1'b1;
      mode    = m;
      x_in    = x;
      thr_in  = t;
      lat     = '{-1, -1};
      n_done8 = 0;
      seen8   = 1'b0;
      seen4   = 1'b0;
      @(posedge clk);
      #1;
      if (hold <= 1) start = 1'b0;
      c = 0;
      while (!(seen8 && seen4) && c < 60) begin
         @(posedge clk);
         #1;
         c++;
         if (c + 1 >= hold) start = 1'b0;
         if (done8) begin
            n_done8++;
            if (!seen8) begin
               seen8    = 1'b1;
               lat[0]   = c;
               got_w[0] = $signed(w8);
               got_t[0] = int'(terms8);
            end
         end
         if (done4 && !seen4) begin
            seen4    = 1'b1;
            lat[1]   = c;
            got_w[1] = $signed(w4);
            got_t[1] = int'(terms4);
         end
      end
      start = 1'b0;
      check("done_seen", seen8 && seen4, 1);
   endtask

   task automatic expect_res(input string tag, input int d, input longint ew, input int et, input int el);
      check({tag, "_w"}, got_w[d], ew);
      check({tag, "_terms"}, got_t[d], et);
      check({tag, "_lat"}, lat[d], el);
   endtask

   initial begin
      res_t r;
      int   extra;
      int   xi;
      bit   rm;
      logic [15:0] rx, rt;

      rst    = 1'b1;
      start  = 1'b0;
      mode   = 1'b0;
      x_in   = '0;
      thr_in = '0;

      // Pin the reference model to hand-derived Q8.8 values.
      r = ref_trig(1'b0, 268, 102, 8);
      check("model_cos_w", r.w, 116);
      check("model_cos_n", r.n, 2);
      r = ref_trig(1'b1, 268, 10, 8);
      check("model_sin_w", r.w, 219);
      check("model_sin_t", r.t, 1);
      r = ref_trig(1'b0, 268, 0, 4);
      check("model_cap_w", r.w, 129);
      check("model_cap_n", r.n, 4);

      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", ready8, 1);
      check("rst_done", done8, 0);
      check("rst_w", w8, 0);
      check("rst_terms", terms8, 0);
      chk_en = 1'b1;

      // cos(pi/3), coarse threshold: -140 added, +13 rejected.
      run(1'b0, 16'h010C, 16'h0066, 1);
      expect_res("cos_thr66_8", 0, 116, 1, 8);
      expect_res("cos_thr66_4", 1, 116, 1, 8);

      // Finer threshold, back-to-back: +13 added, 0 rejected.
      run(1'b0, 16'h010C, 16'h000A, 1);
      expect_res("cos_thr0a_8", 0, 129, 2, 11);
      expect_res("cos_thr0a_4", 1, 129, 2, 11);

      // sin(pi/3): -49 added, +3 rejected.
      run(1'b1, 16'h010C, 16'h000A, 1);
      expect_res("sin_8", 0, 219, 1, 8);
      expect_res("sin_4", 1, 219, 1, 8);

      // Zero threshold runs to the cap.
      run(1'b0, 16'h010C, 16'h0000, 1);
      expect_res("cap_8", 0, 129, 8, 26);
      expect_res("cap_4", 1, 129, 4, 14);

      // start held for three cycles: one run, one done.
      run(1'b0, 16'h010C, 16'h000A, 3);
      expect_res("hold_8", 0, 129, 2, 11);
      extra = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (done8) extra++;
      end
      check("hold_single_done", n_done8 + extra, 1);

      // Reset while in MULR aborts the run without a done pulse.
      @(negedge clk);
      start  = 1'b1;
      mode   = 1'b0;
      x_in   = 16'h010C;
      thr_in = 16'h0066;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("abort_ready", ready8, 1);
      check("abort_done", done8, 0);
      check("abort_w", w8, 0);
      check("abort_terms", terms8, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      run(1'b0, 16'h010C, 16'h0066, 1);
      expect_res("post_abort_8", 0, 116, 1, 8);

      // Randomized runs; the per-cycle compare process does the checking.
      for (int i = 0; i < 150; i++) begin
         rm = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) rx = 16'($urandom);
         else begin
            xi = int'($urandom_range(0, 1536)) - 768;
            rx = 16'(xi);
         end
         rt = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom_range(1, 80));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run(rm, rx, rt, int'($urandom_range(1, 3)));
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/taylor_trig_engine.md
Name: taylor_trig_engine

Overview:
Parametrised iterative fixed-point cosine/sine accelerator, successor to the fixed 16-bit cosine datapath. Evaluates the Taylor series term by term with a multiplier and a reciprocal ROM, stopping when a term drops below a caller-supplied threshold or a term cap is reached. Adds sine mode, configurable width/fraction, a term cap, a done pulse and a term-count output. Sits behind the same start/ready handshake used by the existing accelerators.

Parameters:
W, 16, data width of x_in, thr_in and w (signed two's complement).
FRAC, 8, fractional bits (Q(W-FRAC).FRAC).
MAX_TERMS, 8, maximum correction terms added (1..8); sizes the reciprocal ROM and terms output.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only while ready=1.
mode  input  1  0 = cos, 1 = sin; captured with start.
x_in  input  W  signed angle, captured with start.
thr_in  input  W  unsigned stop threshold, captured with start.
ready  output  1  high in IDLE.
done  output  1  one-cycle pulse when w is updated.
w  output  W  signed result; held until next done.
terms  output  $clog2(MAX_TERMS+1)  correction terms added in the last run.

Behaviour:
- Reset (rst=0, async): state IDLE, ready=1, done=0, w=0, terms=0, internal registers 0. Reset mid-run aborts; no done pulse.
- ROM: R[k] = round(2^FRAC / ((2k+1)(2k+2))) for cos, round(2^FRAC / ((2k+2)(2k+3))) for sin, k=0..MAX_TERMS-1, computed at elaboration. Q8.8 cos: 128,21,9,5,...; sin: 43,13,6,...
- Multiply rule: full 2W-bit signed product, arithmetic shift right by FRAC (floor), truncate to W+2 bits. Accumulator W+2 bits.
- IDLE: ready=1. start=1 at edge -> latch x, thr, mode; ready drops next cycle; go SQ. start while not IDLE ignored.
- SQ (1 cycle): x2 = x*x>>FRAC; term = acc = (mode ? x : 1.0); k=0.
- MULX (1 cycle): term = term*x2>>FRAC.
- MULR (1 cycle): term = -(term*R[k]>>FRAC) (multiply/shift first, then negate).
- CHECK (1 cycle): if |term| < thr -> DONE, term discarded. Else acc += term, k++; if k==MAX_TERMS -> DONE else MULX.
- DONE (1 cycle): w = acc saturated to signed W range; terms = k; done=1; next IDLE.
- Latency: start edge to done = 2 + 3*N cycles, N = iterations evaluated (including the one that failed threshold).
- thr=0: series always runs to MAX_TERMS.

Test Plan:
- Reset idle: rst=0 then release -> ready=1, done=0, w=0, terms=0.
- cos, x=0x010C (pi/3), thr=0x0066 -> iterations: -140 added, +13 rejected; w=0x0074 (116), terms=1, done 8 cycles after start.
- cos, x=0x010C, thr=0x000A -> w=0x0081 (129), terms=2, done 11 cycles after start; back-to-back with the previous run, start pulsed only when ready=1.
- sin, x=0x010C, thr=0x000A -> -49 added, 3 rejected; w=0x00DB (219), terms=1, latency 8.
- Cap: cos, x=0x010C, thr=0, MAX_TERMS=4 -> w=0x0081, terms=4, latency 14.
- Robustness: start held high for 3 cycles during a run -> exactly one done. rst=0 in MULR mid-run -> immediate IDLE, w=0, no done pulse; the next run returns correct results.
